// File: rtl/lfsr_rng_arbiter.sv
// Round-robin arbiter that hands out bytes from a shared 8-bit LFSR.
// After each grant the LFSR advances STEPS_PER_GRANT steps. A seed port can reload it while idle.
module lfsr_rng_arbiter #(
    parameter int         N_REQ           = 4,
    parameter logic [7:0] RESET_SEED      = 8'h8A,
    parameter int         STEPS_PER_GRANT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             rnd_valid,
    output logic [7:0]       rnd_data,
    input  logic             seed_valid,
    input  logic [7:0]       seed_data,
    output logic             seed_ack,
    output logic             busy,
    output logic [7:0]       lfsr_state
);

    localparam int               PTR_W     = $clog2(N_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N_REQ - 1);
    localparam logic [3:0]       STEP_LOAD = 4'(STEPS_PER_GRANT);

    typedef enum logic {IDLE, STEP} state_t;

    state_t           state, state_nx;
    logic [7:0]       lfsr, lfsr_nx;
    logic [PTR_W-1:0] ptr, ptr_nx;
    logic [3:0]       cnt, cnt_nx;
    logic [N_REQ-1:0] gnt_nx;
    logic             rnd_valid_nx;
    logic [7:0]       rnd_data_nx;
    logic             seed_ack_nx;
    logic [PTR_W-1:0] winner;
    logic             found;
    int               idx;

    // An all-zero LFSR would lock up, so zero is always replaced by the reset seed.
    function automatic logic [7:0] zero_guard(input logic [7:0] v);
        return (v == 8'h00) ? RESET_SEED : v;
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return zero_guard({s[7] ^ s[6] ^ s[4] ^ s[1], s[7:1]});
    endfunction

    // Search starts just after the last winner and wraps, giving round-robin fairness.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && req[idx[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_nx     = state;
        lfsr_nx      = lfsr;
        ptr_nx       = ptr;
        cnt_nx       = cnt;
        gnt_nx       = '0;
        rnd_valid_nx = 1'b0;
        rnd_data_nx  = rnd_data;
        seed_ack_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (seed_valid) begin
                    lfsr_nx     = zero_guard(seed_data);
                    seed_ack_nx = 1'b1;
                end else if (found) begin
                    gnt_nx[winner] = 1'b1;
                    rnd_valid_nx   = 1'b1;
                    rnd_data_nx    = lfsr;
                    ptr_nx         = winner;
                    cnt_nx         = STEP_LOAD;
                    state_nx       = STEP;
                end
            end
            STEP: begin
                lfsr_nx = lfsr_step(lfsr);
                cnt_nx  = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lfsr      <= RESET_SEED;
            ptr       <= LAST_IDX;
            cnt       <= 4'd0;
            gnt       <= '0;
            rnd_valid <= 1'b0;
            rnd_data  <= 8'h00;
            seed_ack  <= 1'b0;
        end else begin
            state     <= state_nx;
            lfsr      <= lfsr_nx;
            ptr       <= ptr_nx;
            cnt       <= cnt_nx;
            gnt       <= gnt_nx;
            rnd_valid <= rnd_valid_nx;
            rnd_data  <= rnd_data_nx;
            seed_ack  <= seed_ack_nx;
        end
    end

    assign busy       = (state == STEP);
    assign lfsr_state = lfsr;

endmodule
